// File: rtl/hp2vga_timing_pkg.sv
// Shared types for the VGA sync-stream timing monitor.
// Lock FSM states, measurement tuple and a saturating increment helper.
package hp2vga_timing_pkg;

  localparam int MW = 32;

  typedef enum logic [0:0] {
    ST_SEARCH,
    ST_LOCKED
  } lock_state_e;

  typedef struct packed {
    logic [MW-1:0] htot;
    logic [MW-1:0] hsw;
    logic [MW-1:0] vtot;
    logic [MW-1:0] vsw;
  } meas_t;

  function automatic logic [MW-1:0] sat_inc(
    input logic [MW-1:0] v,
    input logic [MW-1:0] lim
  );
    return (v >= lim) ? lim : v + MW'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchroniser + polarity normalisation for one sync input.
// Ports: clk, rst_n, din (raw) -> rise/fall one-cycle pulses.
module sync_edge #(
  parameter int STAGES     = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  localparam logic IDLE = logic'(ACTIVE_LOW);

  logic [STAGES-1:0] sq;
  logic              act;
  logic              prev;

  assign act  = sq[STAGES-1] ^ IDLE;
  assign rise = act & ~prev;
  assign fall = ~act & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq   <= {STAGES{IDLE}};
      prev <= 1'b0;
    end else begin
      sq   <= {sq[STAGES-2:0], din};
      prev <= act;
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// Measures HSYNC/VSYNC timing per frame and tracks lock.
// Ports: CLK, RESET_N, HS, VS -> H_TOTAL..V_SYNC_W, FRAME_STROBE, LOCKED, LOST.
module vga_timing_monitor
  import hp2vga_timing_pkg::*;
#(
  parameter int CW            = 12,
  parameter int SYNC_STAGES   = 2,
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES   = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          HS,
  input  logic          VS,
  output logic [CW-1:0] H_TOTAL,
  output logic [CW-1:0] H_SYNC_W,
  output logic [CW-1:0] V_TOTAL,
  output logic [CW-1:0] V_SYNC_W,
  output logic          FRAME_STROBE,
  output logic          LOCKED,
  output logic          LOST
);

  localparam int            MCW  = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CPRE = CW'((1 << CW) - 2);

  function automatic logic [CW-1:0] inc_cw(input logic [CW-1:0] v);
    return CW'(sat_inc(MW'(v), MW'(CMAX)));
  endfunction

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  logic [CW-1:0]  pix_cnt, line_cnt;
  logic [CW-1:0]  h_last, hsw_last, vsw_meas;
  logic           pix_ok, h_seen, mism, sat;
  logic           vs_fall_seen, armed;
  logic [MCW-1:0] match_cnt;
  lock_state_e    state;

  logic [CW-1:0]  pix_inc, line_nxt;
  logic [CW-1:0]  h_nxt, hsw_nxt, vsw_nxt;
  logic           h_cap, seen_nxt, mism_nxt;
  logic           sat_nxt, vfs_nxt;
  logic           pix_to, line_to, frame_ok, same;
  logic [MCW-1:0] match_nxt;
  meas_t          cur, pub;

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .ACTIVE_LOW(HS_ACTIVE_LOW)
  ) u_hs (
    .clk  (CLK),
    .rst_n(RESET_N),
    .din  (HS),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .ACTIVE_LOW(VS_ACTIVE_LOW)
  ) u_vs (
    .clk  (CLK),
    .rst_n(RESET_N),
    .din  (VS),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  // Next-state of the frame accumulators; a HS edge coincident
  // with the VS edge is folded in before the frame is published.
  always_comb begin
    pix_inc  = inc_cw(pix_cnt);
    h_cap    = hs_rise & pix_ok;
    line_nxt = hs_rise ? inc_cw(line_cnt) : line_cnt;
    h_nxt    = h_cap ? pix_inc : h_last;
    hsw_nxt  = hs_fall ? pix_inc : hsw_last;
    vsw_nxt  = vs_fall ? line_nxt : vsw_meas;
    seen_nxt = h_seen | h_cap;
    mism_nxt = mism | (h_cap & h_seen & (pix_inc != h_last));
    sat_nxt  = sat | ((h_cap | hs_fall) & (pix_cnt == CMAX));
    vfs_nxt  = vs_fall_seen | vs_fall;
    pix_to   = ~hs_rise & (pix_cnt == CPRE);
    line_to  = hs_rise & (line_cnt == CPRE);
    frame_ok = seen_nxt & ~mism_nxt & ~sat_nxt & vfs_nxt;
    cur = '{htot: MW'(h_nxt), hsw: MW'(hsw_nxt),
            vtot: MW'(line_nxt), vsw: MW'(vsw_nxt)};
    pub = '{htot: MW'(H_TOTAL), hsw: MW'(H_SYNC_W),
            vtot: MW'(V_TOTAL), vsw: MW'(V_SYNC_W)};
    same = (cur == pub);
    if (!frame_ok)
      match_nxt = '0;
    else if (same)
      match_nxt = match_cnt + MCW'(1);
    else
      match_nxt = MCW'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      h_last       <= '0;
      hsw_last     <= '0;
      vsw_meas     <= '0;
      pix_ok       <= 1'b0;
      h_seen       <= 1'b0;
      mism         <= 1'b0;
      sat          <= 1'b0;
      vs_fall_seen <= 1'b0;
      armed        <= 1'b0;
      match_cnt    <= '0;
      state        <= ST_SEARCH;
      H_TOTAL      <= '0;
      H_SYNC_W     <= '0;
      V_TOTAL      <= '0;
      V_SYNC_W     <= '0;
      FRAME_STROBE <= 1'b0;
      LOCKED       <= 1'b0;
      LOST         <= 1'b0;
    end else begin
      FRAME_STROBE <= 1'b0;
      LOST         <= 1'b0;
      pix_cnt      <= hs_rise ? '0 : pix_inc;
      line_cnt     <= line_nxt;
      h_last       <= h_nxt;
      hsw_last     <= hsw_nxt;
      vsw_meas     <= vsw_nxt;
      h_seen       <= seen_nxt;
      mism         <= mism_nxt;
      sat          <= sat_nxt;
      vs_fall_seen <= vfs_nxt;
      // A saturated pixel count cannot start a valid line.
      if (hs_rise)
        pix_ok <= 1'b1;
      else if (pix_to)
        pix_ok <= 1'b0;
      if (pix_to || line_to) begin
        armed     <= 1'b0;
        state     <= ST_SEARCH;
        match_cnt <= '0;
        LOCKED    <= 1'b0;
        LOST      <= LOCKED;
      end else if (vs_rise) begin
        line_cnt     <= '0;
        h_seen       <= 1'b0;
        mism         <= 1'b0;
        sat          <= 1'b0;
        vs_fall_seen <= 1'b0;
        armed        <= 1'b1;
        if (armed) begin
          H_TOTAL      <= h_nxt;
          H_SYNC_W     <= hsw_nxt;
          V_TOTAL      <= line_nxt;
          V_SYNC_W     <= vsw_nxt;
          FRAME_STROBE <= 1'b1;
          unique case (state)
            ST_SEARCH: begin
              match_cnt <= match_nxt;
              if (match_nxt == MCW'(LOCK_FRAMES)) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end
            end
            ST_LOCKED: begin
              if (!(frame_ok && same)) begin
                state     <= ST_SEARCH;
                match_cnt <= frame_ok ? MCW'(1) : '0;
                LOCKED    <= 1'b0;
                LOST      <= 1'b1;
              end
            end
            default: state <= ST_SEARCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Self-checking bench for vga_timing_monitor.
// Runs active-low and active-high instances against one frame-level model.
module tb_vga_timing_monitor;

  localparam int CW = 12;
  localparam int SS = 2;
  localparam int LF = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hs_a  = 1'b0;
  logic vs_a  = 1'b0;
  logic hs_l, vs_l;

  assign hs_l = ~hs_a;
  assign vs_l = ~vs_a;

  always #5 clk = ~clk;

  logic [CW-1:0] a_ht, a_hw, a_vt, a_vw;
  logic          a_fs, a_lk, a_lo;
  logic [CW-1:0] b_ht, b_hw, b_vt, b_vw;
  logic          b_fs, b_lk, b_lo;

  vga_timing_monitor #(
    .CW(CW), .SYNC_STAGES(SS),
    .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1),
    .LOCK_FRAMES(LF)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .HS(hs_l), .VS(vs_l),
    .H_TOTAL(a_ht), .H_SYNC_W(a_hw),
    .V_TOTAL(a_vt), .V_SYNC_W(a_vw),
    .FRAME_STROBE(a_fs), .LOCKED(a_lk), .LOST(a_lo)
  );

  vga_timing_monitor #(
    .CW(CW), .SYNC_STAGES(SS),
    .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0),
    .LOCK_FRAMES(LF)
  ) dut_hi (
    .CLK(clk), .RESET_N(rst_n), .HS(hs_a), .VS(vs_a),
    .H_TOTAL(b_ht), .H_SYNC_W(b_hw),
    .V_TOTAL(b_vt), .V_SYNC_W(b_vw),
    .FRAME_STROBE(b_fs), .LOCKED(b_lk), .LOST(b_lo)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: lines are kept as a list of measured lengths,
  // the pixel count is the distance to the last zeroing edge.
  int n = 0, zero_e = 0, k_last = 0;
  int last_h, hsw_v, vsw_v, hs_cnt, run;
  bit have_ref, armed, lk, fsat, vfs, last_in;
  int lines[$];
  bit hq[$], vq[$];
  logic [CW-1:0] e_ht, e_hw, e_vt, e_vw;
  bit e_fs, e_lk, e_lo;

  always @(posedge clk) begin
    bit hr, hf, vr, vf, to, valid, same;
    int pix;
    n++;
    if (!rst_n) begin
      zero_e = n; have_ref = 0; armed = 0; lk = 0; run = 0;
      last_h = 0; hsw_v = 0; vsw_v = 0; hs_cnt = 0;
      fsat = 0; vfs = 0; last_in = 0;
      lines.delete();
      hq.delete(); vq.delete();
      repeat (SS + 1) begin hq.push_back(1'b0); vq.push_back(1'b0); end
      e_ht = '0; e_hw = '0; e_vt = '0; e_vw = '0;
      e_fs = 0; e_lk = 0; e_lo = 0;
    end else begin
      hr = hq[1] && !hq[0];
      hf = !hq[1] && hq[0];
      vr = vq[1] && !vq[0];
      vf = !vq[1] && vq[0];
      void'(hq.pop_front()); hq.push_back(hs_a);
      void'(vq.pop_front()); vq.push_back(vs_a);
      if (hs_a && !last_in) k_last = n;
      last_in = hs_a;
      pix = n - 1 - zero_e;
      if (pix > 4095) pix = 4095;
      e_fs = 0; e_lo = 0; to = 0;
      if (hr) begin
        if (have_ref) begin
          last_h = (pix == 4095) ? 4095 : pix + 1;
          lines.push_back(last_h);
          if (pix == 4095) fsat = 1;
        end
        have_ref = 1;
        zero_e = n;
        if (hs_cnt == 4094) to = 1;
        if (hs_cnt < 4095) hs_cnt++;
      end else if (pix == 4094) begin
        to = 1;
        have_ref = 0;
      end
      if (hf) begin
        hsw_v = (pix == 4095) ? 4095 : pix + 1;
        if (pix == 4095) fsat = 1;
      end
      if (vf) begin
        vsw_v = hs_cnt;
        vfs = 1;
      end
      if (to) begin
        armed = 0; run = 0;
        e_lo = lk;
        lk = 0;
      end else if (vr) begin
        if (armed) begin
          valid = lines.size() > 0 && !fsat && vfs;
          foreach (lines[i]) if (lines[i] != lines[0]) valid = 0;
          same = last_h == e_ht && hsw_v == e_hw &&
                 hs_cnt == e_vt && vsw_v == e_vw;
          e_ht = CW'(last_h); e_hw = CW'(hsw_v);
          e_vt = CW'(hs_cnt); e_vw = CW'(vsw_v);
          e_fs = 1;
          if (lk) begin
            if (!(valid && same)) begin
              lk = 0; e_lo = 1; run = valid ? 1 : 0;
            end
          end else begin
            run = !valid ? 0 : (same ? run + 1 : 1);
            if (run >= LF) lk = 1;
          end
        end
        armed = 1;
        lines.delete();
        hs_cnt = 0; fsat = 0; vfs = 0;
      end
      e_lk = lk;
    end
  end

  int strobe_cnt = 0, lost_cnt = 0;
  int lock_at = 0, lost_at = 0, lost_edge = 0;
  bit prev_lk = 0;

  always @(negedge clk) begin
    logic [50:0] ev, av, bv;
    ev = {e_ht, e_hw, e_vt, e_vw, e_fs, e_lk, e_lo};
    av = {a_ht, a_hw, a_vt, a_vw, a_fs, a_lk, a_lo};
    bv = {b_ht, b_hw, b_vt, b_vw, b_fs, b_lk, b_lo};
    tests++;
    if (av !== ev) begin
      fails++;
      $display("FAIL cyc_lo @%0d: got %h, want %h", n, av, ev);
    end
    tests++;
    if (bv !== ev) begin
      fails++;
      $display("FAIL cyc_hi @%0d: got %h, want %h", n, bv, ev);
    end
    if (a_fs) strobe_cnt++;
    if (a_lo) begin
      lost_cnt++;
      lost_at = strobe_cnt;
      lost_edge = n;
    end
    if (a_lk && !prev_lk) lock_at = strobe_cnt;
    prev_lk = a_lk;
  end

  task automatic idle(input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      hs_a = 1'b0;
      vs_a = 1'b0;
    end
  endtask

  // One frame: 20 lines, HS active first 10 pixels, VS active 3 lines
  // starting at pixel vs_off of line 0; line 'bad' is 101 long.
  task automatic frame(input int vs_off, input int bad, input int nl);
    int ht;
    for (int l = 0; l < nl; l++) begin
      ht = (l == bad) ? 101 : 100;
      for (int p = 0; p < ht; p++) begin
        @(negedge clk);
        hs_a = (p < 10);
        vs_a = (l < 3 && !(l == 0 && p < vs_off)) ||
               (l == 3 && p < vs_off);
      end
    end
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ht", a_ht, 0);
    chk("rst_lock", a_lk, 0);
    chk("rst_hi_vt", b_vt, 0);
    rst_n = 1'b1;
    idle(20);

    repeat (6) frame(50, -1, 20);
    chk("clean_strobes", strobe_cnt, 5);
    chk("clean_lock_at", lock_at, 4);
    chk("clean_ht", a_ht, 100);
    chk("clean_hw", a_hw, 10);
    chk("clean_vt", a_vt, 20);
    chk("clean_vw", a_vw, 3);
    chk("clean_lost", lost_cnt, 0);
    chk("clean_locked", a_lk, 1);

    s0 = strobe_cnt;
    frame(50, 5, 20);
    repeat (5) frame(50, -1, 20);
    chk("dist_lost_cnt", lost_cnt, 1);
    chk("dist_lost_at", lost_at, s0 + 2);
    chk("dist_lock_at", lock_at, s0 + 6);
    chk("dist_locked", a_lk, 1);

    s0 = strobe_cnt;
    idle(4200);
    chk("stuck_lost_cnt", lost_cnt, 2);
    chk("stuck_lost_delay", lost_edge - k_last, SS + 4095);
    chk("stuck_locked", a_lk, 0);
    chk("stuck_strobes", strobe_cnt, s0);
    chk("stuck_ht", a_ht, 100);
    chk("stuck_hw", a_hw, 10);
    chk("stuck_vt", a_vt, 20);
    chk("stuck_vw", a_vw, 3);

    s0 = strobe_cnt;
    repeat (3) frame(50, -1, 20);
    chk("resume_strobes", strobe_cnt - s0, 2);

    frame(50, -1, 8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ht", a_ht, 0);
    chk("arst_vw", a_vw, 0);
    chk("arst_hi_hw", b_hw, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    s0 = strobe_cnt;
    frame(0, -1, 20);
    chk("post_rst_no_strobe", strobe_cnt, s0);
    repeat (5) frame(0, -1, 20);
    chk("coin_strobes", strobe_cnt - s0, 5);
    chk("coin_lock_at", lock_at, s0 + 4);
    chk("coin_vt", a_vt, 20);
    chk("coin_vw", a_vw, 3);
    chk("coin_locked", a_lk, 1);
    chk("coin_hi_locked", b_lk, 1);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side checker for the VGA sync stream that the transmitter drives towards the ADV DAC (HSYNC/VSYNC).
- Measures horizontal total, HSYNC width, vertical total and VSYNC width, and publishes them once per frame.
- Declares LOCKED after a run of identical valid frames.
- Used on-board as a self-test and loop-back monitor. Its outputs drive the debug header, the LED logic and bench scoreboards.

Parameters:
CW, 12, width of all counters and measurement outputs; all counters saturate at 2^CW-1
SYNC_STAGES, 2, synchroniser flops per sync input (min 2)
HS_ACTIVE_LOW, 1, 1: HS pulse is low, 0: HS pulse is high
VS_ACTIVE_LOW, 1, 1: VS pulse is low, 0: VS pulse is high
LOCK_FRAMES, 4, consecutive identical valid frames required to assert LOCKED (>=2)

Ports:
CLK  in  1  single clock for the block (TX pixel clock domain)
RESET_N  in  1  asynchronous, active-low reset
HS  in  1  horizontal sync, polarity per HS_ACTIVE_LOW
VS  in  1  vertical sync, polarity per VS_ACTIVE_LOW
H_TOTAL  out  CW  CLK cycles between consecutive HS leading edges
H_SYNC_W  out  CW  CLK cycles HS active
V_TOTAL  out  CW  HS leading edges per frame
V_SYNC_W  out  CW  HS leading edges while VS active
FRAME_STROBE  out  1  one-cycle pulse when a completed frame is published
LOCKED  out  1  timing stable
LOST  out  1  one-cycle pulse on a LOCKED 1->0 transition

Behaviour:
- Reset (RESET_N low, asynchronous):
  - all outputs are 0;
  - synchroniser flops are loaded with the inactive level;
  - all counters, valid flags and the FSM are cleared.
- Input conditioning:
  - each input passes through SYNC_STAGES flops and is normalised to active-high.
  - Leading edge = inactive->active; trailing edge = active->inactive, detected on the last synchroniser stage.
- Latency: if an input edge is first sampled at CLK edge k, the resulting register updates (including FRAME_STROBE) occur at edge k+SYNC_STAGES.
- pix_cnt: increments every cycle and saturates.
  - On HS leading edge: capture h_meas = pix_cnt+1, then reset pix_cnt to 0.
  - On HS trailing edge: capture hsw_meas = pix_cnt+1.
  - If saturated, the captured value is all-ones and the frame is invalid.
- Per-line consistency: within a frame, every h_meas after the first must equal the previous h_meas; any difference marks the frame bad.
- The first HS leading edge after reset, or after any pix_cnt saturation, produces no h_meas.
- line_cnt: increments on each HS leading edge and saturates.
  - On VS leading edge: v_meas = line_cnt; line_cnt is cleared.
  - On VS trailing edge: vsw_meas = number of HS leading edges since the VS leading edge.
- Coincident HS and VS leading edges in the same cycle: the HS edge counts towards the ending frame. V_TOTAL counts HS edges in (previous VS edge, this VS edge].
- Publish:
  - The first VS leading edge after reset or a timeout only arms the block; there is no strobe.
  - On each later VS leading edge: register H_TOTAL/H_SYNC_W (last line values), V_TOTAL and V_SYNC_W (from the ending frame), and pulse FRAME_STROBE.
  - Published values are held until the next publish.
- Frame valid: no saturation, no per-line mismatch, at least one h_meas, VS trailing edge seen.
- Lock FSM states SEARCH, LOCKED:
  - SEARCH: a valid frame equal to the previous published tuple increments match_cnt. Any other valid frame sets match_cnt=1; an invalid frame sets match_cnt=0. When match_cnt reaches LOCK_FRAMES, move to LOCKED, and LOCKED rises with that FRAME_STROBE.
  - LOCKED: an invalid or differing frame -> SEARCH with match_cnt=0 (or 1 if valid), LOCKED=0 and a LOST pulse, both with that strobe.
  - Timeout: pix_cnt or line_cnt reaching saturation forces SEARCH immediately, disarms publish and pulses LOST if LOCKED was set. Measurement outputs hold their values.
- Reset mid-frame: everything clears; at least two VS leading edges are needed before the next FRAME_STROBE.

Decomposition:
- Package hp2vga_timing_pkg: FSM state enum (ST_SEARCH, ST_LOCKED), a measurement-tuple struct {htot, hsw, vtot, vsw}, and a saturating-increment function.
- Sub-module sync_edge: synchroniser, polarity normalisation and rise/fall pulses. Instanced for HS and VS.

Test Plan (all scenarios: active-low HS/VS unless stated, CW=12, LOCK_FRAMES=4):
- Clean run: frames with HTOTAL=100, HSW=10, VTOTAL=20, VSW=3 -> no strobe at the first VS edge; strobes afterwards with outputs 100/10/20/3; LOCKED rises with the 4th strobe; LOST stays 0.
- Disturbance: after lock, one line of the next frame has HTOTAL=101 -> that frame's strobe drops LOCKED and pulses LOST; LOCKED returns 4 clean frames later.
- HS stuck inactive while LOCKED -> LOCKED=0 and LOST pulse at pix_cnt=4095; outputs hold 100/10/20/3; the next strobe needs two VS edges.
- HS leading edge coincident with every VS leading edge -> V_TOTAL=20, V_SYNC_W=3, LOCKED after 4 strobes.
- RESET_N low mid-frame for 3 cycles -> all outputs 0 asynchronously; the first strobe after release comes at the second VS edge.
- HS_ACTIVE_LOW=0, VS_ACTIVE_LOW=0 with inverted stimulus -> results identical to the clean run.
